// File: rtl/bidir_serial_port.sv
// Half-duplex serial port on one shared line: UART-style frames out, frames in,
// with a fixed idle turnaround after every frame before the line is reused.
module bidir_serial_port #(
  parameter int BIT_CYC  = 4,
  parameter int TURN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  input  logic       bus_i,
  output logic       bus_o,
  output logic       en
);

  localparam int CNT_MAX = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURN_CYC - 1);
  // Preloading half a bit makes every receive sample land at mid-bit.
  localparam logic [CW-1:0] HALF_BIT  = CW'(BIT_CYC / 2);

  typedef enum logic [1:0] {IDLE, TX, TURN, RX} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          tx_ready_q, tx_ready_d;
  logic          bus_o_q, bus_o_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_ready_q <= 1'b0;
      bus_o_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      tx_ready_q <= tx_ready_d;
      bus_o_q    <= bus_o_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    bus_o_d    = 1'b1;
    case (state_q)
      IDLE: begin
        // A low line wins over a pending transmit request.
        if (!bus_i) begin
          state_d = RX;
          cnt_d   = HALF_BIT;
          bit_d   = '0;
        end else if (tx_valid && tx_ready_q) begin
          state_d = TX;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = tx_data;
          bus_o_d = 1'b0;
        end
      end
      TX: begin
        bus_o_d = bus_o_q;
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            state_d = TURN;
            bus_o_d = 1'b1;
          end else begin
            // Ones shifted in from the top become the stop bit after d7.
            bit_d   = bit_q + 4'd1;
            bus_o_d = shift_q[0];
            shift_d = {1'b1, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q == 4'd0) begin
            if (bus_i) begin
              state_d = IDLE;
              bit_d   = '0;
            end
          end else if (bit_q == 4'd9) begin
            state_d = TURN;
            if (bus_i) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              rx_err_d = 1'b1;
            end
          end else begin
            shift_d = {bus_i, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready_d = (state_d == IDLE);

  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_err   = rx_err_q;
  assign bus_o    = bus_o_q;
  // Decoded straight from state so an asynchronous reset releases the line at once.
  assign en       = (state_q == TX);

endmodule

// File: tb/tb_bidir_serial_port.sv
// Directed bench for bidir_serial_port: transmit, receive, framing error, false start,
// collision priority and mid-frame reset, checked against queued expectations.
module tb_bidir_serial_port;
  localparam int BIT_CYC  = 4;
  localparam int TURN_CYC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ext_line = 1'b1;
  logic       tx_ready, rx_valid, rx_err, bus_o, en, bus_i;
  logic [7:0] rx_data;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       exp_bits[$];
  logic [7:0] exp_rx[$];

  // Shared line: our driver when enabled, otherwise the remote end (pull-up idle).
  assign bus_i = en ? bus_o : ext_line;

  bidir_serial_port #(.BIT_CYC(BIT_CYC), .TURN_CYC(TURN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .bus_i(bus_i), .bus_o(bus_o), .en(en)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call at the falling edge right after the acceptance edge.
  task automatic check_tx_frame(input logic [7:0] d);
    logic b;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(1'b1);
    for (int k = 0; k < 10; k++) begin
      b = exp_bits.pop_front();
      for (int c = 0; c < BIT_CYC; c++) begin
        check($sformatf("tx_bit%0d_bus_o", k), 32'(bus_o), 32'(b));
        check("tx_en", 32'(en), 32'd1);
        check("tx_ready_busy", 32'(tx_ready), 32'd0);
        check("tx_no_rx_pulse", 32'(rx_valid | rx_err), 32'd0);
        @(negedge clk);
      end
    end
    for (int t = 0; t < TURN_CYC; t++) begin
      check("turn_en", 32'(en), 32'd0);
      check("turn_bus_o", 32'(bus_o), 32'd1);
      check("turn_tx_ready", 32'(tx_ready), 32'd0);
      @(negedge clk);
    end
    check("tx_ready_after_turn", 32'(tx_ready), 32'd1);
    $display("tx frame %02h checked", d);
  endtask

  // Drives one frame from the remote end; reports pulse counts and the cycle index of the pulse.
  task automatic drive_rx(input logic [7:0] d, input logic stop,
                          output int nv, output int ne, output int pos);
    logic [9:0] frame;
    frame = {stop, d, 1'b0};
    nv = 0; ne = 0; pos = -1;
    if (stop) exp_rx.push_back(d);
    for (int k = 0; k < 10; k++) begin
      ext_line = frame[k];
      for (int c = 0; c < BIT_CYC; c++) begin
        @(negedge clk);
        check("rx_en_low", 32'(en), 32'd0);
        if (rx_valid) begin
          nv++;
          pos = k * BIT_CYC + c;
          if (exp_rx.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        if (rx_err) begin
          ne++;
          pos = k * BIT_CYC + c;
        end
      end
    end
    ext_line = 1'b1;
    $display("rx frame %02h stop=%0b: valid=%0d err=%0d", d, stop, nv, ne);
  endtask

  initial begin
    int nv, ne, pos, npulse;

    // Reset state
    @(negedge clk);
    check("rst_en", 32'(en), 32'd0);
    check("rst_bus_o", 32'(bus_o), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_err", 32'(rx_err), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("tx_ready_after_release", 32'(tx_ready), 32'd1);

    // Transmit 0xA5
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk);
    tx_valid = 1'b0;
    check_tx_frame(8'hA5);
    repeat (2) @(negedge clk);

    // Receive 0x3C with a good stop bit
    drive_rx(8'h3C, 1'b1, nv, ne, pos);
    check("rx3c_valid_count", 32'(nv), 32'd1);
    check("rx3c_err_count", 32'(ne), 32'd0);
    check("rx3c_pulse_pos", 32'(pos), 32'(9 * BIT_CYC + BIT_CYC / 2));
    check("rx3c_data", 32'(rx_data), 32'h3C);
    repeat (3) @(negedge clk);

    // Framing error: stop bit low
    drive_rx(8'h81, 1'b0, nv, ne, pos);
    check("rxerr_valid_count", 32'(nv), 32'd0);
    check("rxerr_err_count", 32'(ne), 32'd1);
    check("rxerr_pulse_pos", 32'(pos), 32'(9 * BIT_CYC + BIT_CYC / 2));
    check("rxerr_data_kept", 32'(rx_data), 32'h3C);
    repeat (3) @(negedge clk);
    check("idle_after_err", 32'(tx_ready), 32'd1);

    // False start: line low for one clock
    ext_line = 1'b0;
    @(negedge clk);
    ext_line = 1'b1;
    npulse = 0;
    check("fs_ready_in_rx0", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("fs_ready_in_rx1", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("fs_ready_after_sample", 32'(tx_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (rx_valid || rx_err) npulse++;
      @(negedge clk);
    end
    check("fs_no_pulses", 32'(npulse), 32'd0);
    $display("false start checked");

    // Collision: receive wins, transmit follows after turnaround
    tx_valid = 1'b1; tx_data = 8'h5A;
    drive_rx(8'h96, 1'b1, nv, ne, pos);
    check("col_valid_count", 32'(nv), 32'd1);
    check("col_rx_data", 32'(rx_data), 32'h96);
    @(negedge clk);
    check("col_ready_before_accept", 32'(tx_ready), 32'd1);
    check("col_not_driving_yet", 32'(en), 32'd0);
    @(negedge clk);
    tx_valid = 1'b0;
    check_tx_frame(8'h5A);
    repeat (2) @(negedge clk);

    // Reset in the middle of a transmit frame
    tx_valid = 1'b1; tx_data = 8'h00;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_en_before_rst", 32'(en), 32'd1);
    check("mid_bus_o_before_rst", 32'(bus_o), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_en_async", 32'(en), 32'd0);
    check("mid_rst_bus_o_async", 32'(bus_o), 32'd1);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("mid_rst_held_en", 32'(en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_release_tx_ready", 32'(tx_ready), 32'd1);
    check("mid_release_en", 32'(en), 32'd0);
    check("mid_release_bus_o", 32'(bus_o), 32'd1);
    $display("mid-frame reset checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bidir_serial_port.md
BIDIR_SERIAL_PORT -- requirements
Module: bidir_serial_port

Interface
REQ-001 SHALL have parameter BIT_CYC, default 4: clocks per serial bit; even, >=2.
REQ-002 SHALL have parameter TURN_CYC, default 2: bus turnaround idle clocks after every frame; >=1.
REQ-003 SHALL have a single clock, clk (input, 1): all state changes on its rising edge.
REQ-004 SHALL have rst_n (input, 1): reset, asynchronous, active-low.
REQ-005 SHALL have tx_valid (input, 1): the user presents a byte to send.
REQ-006 SHALL have tx_data (input, 8): the byte to send; sampled at acceptance.
REQ-007 SHALL have tx_ready (output, 1): the port can accept a byte.
REQ-008 SHALL have rx_data (output, 8): the last correctly received byte.
REQ-009 SHALL have rx_valid (output, 1): one-cycle pulse when rx_data updates.
REQ-010 SHALL have rx_err (output, 1): one-cycle pulse on a framing error.
REQ-011 SHALL have bus_i (input, 1): the shared line as seen through the bidirectional buffer.
REQ-012 SHALL have bus_o (output, 1): the value driven onto the shared line.
REQ-013 SHALL have en (output, 1): buffer direction; 1 = this port drives the line, 0 = line released and readable.

Function
REQ-014 SHALL implement the states IDLE, TX, TURN, RX; the line idles high (external pull-up).
REQ-015 SHALL use this frame: start bit 0, 8 data bits LSB first, stop bit 1, each held BIT_CYC clocks.
REQ-016 SHALL drive tx_ready as a register: 1 only while the state is IDLE; 0 in all other states.
REQ-017 SHALL accept a byte when tx_valid&tx_ready is 1 at an edge in IDLE with bus_i=1: latch tx_data and move to TX.
REQ-018 SHALL, in TX, hold en=1 for exactly 10*BIT_CYC clocks starting the cycle after acceptance, with bus_o following the frame.
REQ-019 SHALL, after the stop bit, drop en to 0 and bus_o to 1, stay in TURN for TURN_CYC clocks, then enter IDLE.
REQ-020 SHALL move from IDLE to RX on an edge where bus_i=0 (start detect, edge E0); en stays 0 throughout RX.
REQ-021 SHALL sample bus_i at edges E0+BIT_CYC/2+n*BIT_CYC for n=0..9 (start, d0..d7, stop).
REQ-022 SHALL treat start-sample=1 as a false start: return to IDLE with no rx_valid and no rx_err.
REQ-023 SHALL, on stop-sample=1, update rx_data and pulse rx_valid for the one cycle following that edge.
REQ-024 SHALL, on stop-sample=0, pulse rx_err for one cycle and leave rx_data unchanged.
REQ-025 SHALL, after the stop sample, go to TURN for TURN_CYC clocks, then IDLE.
REQ-026 SHALL give receive priority on collision: in IDLE with bus_i=0 and tx_valid=1, enter RX and accept no byte; tx_valid stays pending.
REQ-027 SHALL ignore bus_i in TX and TURN; rx_valid and rx_err SHALL never assert in TX.
REQ-028 SHALL never assert en outside TX.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronous): state IDLE, en=0, bus_o=1, tx_ready=0, rx_valid=0, rx_err=0, rx_data=8'h00, all counters 0.
REQ-030 SHALL abandon any partial frame on reset; en SHALL drop without waiting for a clock.
REQ-031 SHALL raise tx_ready at the first clock edge after rst_n deasserts, unless bus_i=0 (then RX).

Verification
REQ-032 TX 0xA5 with defaults -> bus_o 0,1,0,1,0,0,1,0,1,1 (4 clocks each); en=1 for 40 clocks; tx_ready=0 for 40+2 clocks; then tx_ready=1.
REQ-033 RX 0x3C driven on bus_i with a valid frame -> rx_data=8'h3C; rx_valid one-cycle pulse one clock after the stop sample; en=0 throughout.
REQ-034 RX frame with stop bit=0 -> rx_err one-cycle pulse; rx_valid=0; rx_data unchanged.
REQ-035 bus_i low for one clock only in IDLE -> false start; IDLE again after the start sample; no pulses.
REQ-036 tx_valid=1 with bus_i falling in the same cycle -> RX taken; byte accepted only after RX+TURN completes; tx then proceeds per REQ-032.
REQ-037 rst_n low at clock 15 of a TX frame -> en=0 and bus_o=1 immediately; tx_ready=1 one edge after release.
